// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit, datapath muxes and ALU control.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_WB_R     = 4'd4,
    S_EXEC_I   = 4'd5,
    S_WB_I     = 4'd6,
    S_MEM_ADDR = 4'd7,
    S_MEM_RD   = 4'd8,
    S_MEM_WB   = 4'd9,
    S_MEM_WR   = 4'd10,
    S_BRANCH   = 4'd11,
    S_JAL      = 4'd12
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_JAL: op_legal = 1'b1;
      default:                                        op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational control-word decode of the current control state.
// Memory strobes follow the FSM; write strobes in FETCH are qualified by mem_ready.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_HANDSHAKE = 1,
  parameter int ALUOP_W       = 2
) (
  input  state_t             state,
  input  logic               mem_ready,
  input  logic [5:0]         opcode,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic [1:0]         reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         pc_source,
  output logic               illegal_op
);

  logic mem_done;
  assign mem_done = (MEM_HANDSHAKE == 0) || mem_ready;

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = DST_RT;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_RT;
    alu_op        = ALUOP_W'(ALU_ADD);
    pc_source     = PCS_ALU;
    illegal_op    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = mem_done;
        pc_write  = mem_done;
        alu_src_b = SRCB_FOUR;
      end
      S_DECODE: begin
        alu_src_b  = SRCB_IMM_SH;
        illegal_op = !op_legal(opcode);
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_W'(ALU_FUNCT);
      end
      S_WB_R: begin
        reg_dst   = DST_RD;
        reg_write = 1'b1;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_W'(ALU_SUB);
      end
      S_WB_I: reg_write = 1'b1;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_W'(ALU_SUB);
        pc_write_cond = 1'b1;
        pc_source     = PCS_ALUOUT;
      end
      S_JAL: begin
        pc_write  = 1'b1;
        pc_source = PCS_JUMP;
        reg_dst   = DST_RA;
        reg_write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS main control: state register, next-state sequencing, retired counter.
// mem_ready: memory completes the access in any cycle it is high while a strobe is up.
module multicycle_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_HANDSHAKE = 1,
  parameter int RETIRE_W      = 32,
  parameter int ALUOP_W       = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                iord,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                mem_to_reg,
  output logic [1:0]          reg_dst,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic [1:0]          pc_source,
  output logic                illegal_op,
  output logic [RETIRE_W-1:0] retired
);

  state_t state;
  logic   mem_done;

  assign mem_done = (MEM_HANDSHAKE == 0) || mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      retired <= '0;
    end else begin
      case (state)
        S_IDLE:   state <= S_FETCH;
        S_FETCH:  if (mem_done) state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_RTYPE:     state <= S_EXEC_R;
            OP_ORI:       state <= S_EXEC_I;
            OP_LW, OP_SW: state <= S_MEM_ADDR;
            OP_BEQ:       state <= S_BRANCH;
            OP_JAL:       state <= S_JAL;
            default:      state <= S_FETCH;
          endcase
        end
        S_EXEC_R:   state <= S_WB_R;
        S_EXEC_I:   state <= S_WB_I;
        S_MEM_ADDR: state <= (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD:   if (mem_done) state <= S_MEM_WB;
        S_WB_R, S_WB_I, S_MEM_WB, S_BRANCH, S_JAL: begin
          state   <= S_FETCH;
          retired <= retired + RETIRE_W'(1);
        end
        S_MEM_WR: begin
          if (mem_done) begin
            state   <= S_FETCH;
            retired <= retired + RETIRE_W'(1);
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

  mc_ctrl_decode #(
    .MEM_HANDSHAKE(MEM_HANDSHAKE),
    .ALUOP_W      (ALUOP_W)
  ) u_decode (
    .state        (state),
    .mem_ready    (mem_ready),
    .opcode       (opcode),
    .pc_write     (pc_write),
    .pc_write_cond(pc_write_cond),
    .iord         (iord),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .ir_write     (ir_write),
    .mem_to_reg   (mem_to_reg),
    .reg_dst      (reg_dst),
    .reg_write    (reg_write),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .pc_source    (pc_source),
    .illegal_op   (illegal_op)
  );

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench: dut_a runs with the memory handshake, dut_b without it and a 4-bit counter.
module tb_multicycle_control_fsm;

  // Control word: {pcw,pcwc,iord,mrd,mwr,irw,m2r, reg_dst, rw, asa, alu_src_b, alu_op, pc_source, ill}
  localparam logic [17:0] E_IDLE     = 18'd0;
  localparam logic [17:0] E_FETCH    = {7'b1001010, 2'b00, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0};
  localparam logic [17:0] E_FETCH_W  = {7'b0001000, 2'b00, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0};
  localparam logic [17:0] E_DECODE   = {7'b0000000, 2'b00, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0};
  localparam logic [17:0] E_ILLEGAL  = {7'b0000000, 2'b00, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b1};
  localparam logic [17:0] E_EXEC_R   = {7'b0000000, 2'b00, 1'b0, 1'b1, 2'b00, 2'b10, 2'b00, 1'b0};
  localparam logic [17:0] E_WB_R     = {7'b0000000, 2'b01, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [17:0] E_EXEC_I   = {7'b0000000, 2'b00, 1'b0, 1'b1, 2'b10, 2'b01, 2'b00, 1'b0};
  localparam logic [17:0] E_WB_I     = {7'b0000000, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [17:0] E_MEM_ADDR = {7'b0000000, 2'b00, 1'b0, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0};
  localparam logic [17:0] E_MEM_RD   = {7'b0011000, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [17:0] E_MEM_WB   = {7'b0000001, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [17:0] E_MEM_WR   = {7'b0010100, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [17:0] E_BRANCH   = {7'b0100000, 2'b00, 1'b0, 1'b1, 2'b00, 2'b01, 2'b01, 1'b0};
  localparam logic [17:0] E_JAL      = {7'b1000000, 2'b10, 1'b1, 1'b0, 2'b00, 2'b00, 2'b10, 1'b0};

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] JUNK     = 6'b111111;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b, rdy_a, rdy_b;
  logic [5:0] op_a, op_b;

  logic        pcw_a, pcwc_a, iord_a, mrd_a, mwr_a, irw_a, m2r_a, rw_a, asa_a, ill_a;
  logic [1:0]  rdst_a, asb_a, aop_a, psrc_a;
  logic [31:0] retired_a;
  logic        pcw_b, pcwc_b, iord_b, mrd_b, mwr_b, irw_b, m2r_b, rw_b, asa_b, ill_b;
  logic [1:0]  rdst_b, asb_b, aop_b, psrc_b;
  logic [3:0]  retired_b;

  logic [17:0] cw_a, cw_b;
  assign cw_a = {pcw_a, pcwc_a, iord_a, mrd_a, mwr_a, irw_a, m2r_a, rdst_a, rw_a, asa_a,
                 asb_a, aop_a, psrc_a, ill_a};
  assign cw_b = {pcw_b, pcwc_b, iord_b, mrd_b, mwr_b, irw_b, m2r_b, rdst_b, rw_b, asa_b,
                 asb_b, aop_b, psrc_b, ill_b};

  multicycle_control_fsm #(.MEM_HANDSHAKE(1), .RETIRE_W(32), .ALUOP_W(2)) dut_a (
    .clk(clk), .rst_n(rst_a), .opcode(op_a), .mem_ready(rdy_a),
    .pc_write(pcw_a), .pc_write_cond(pcwc_a), .iord(iord_a), .mem_read(mrd_a),
    .mem_write(mwr_a), .ir_write(irw_a), .mem_to_reg(m2r_a), .reg_dst(rdst_a),
    .reg_write(rw_a), .alu_src_a(asa_a), .alu_src_b(asb_a), .alu_op(aop_a),
    .pc_source(psrc_a), .illegal_op(ill_a), .retired(retired_a)
  );

  multicycle_control_fsm #(.MEM_HANDSHAKE(0), .RETIRE_W(4), .ALUOP_W(2)) dut_b (
    .clk(clk), .rst_n(rst_b), .opcode(op_b), .mem_ready(rdy_b),
    .pc_write(pcw_b), .pc_write_cond(pcwc_b), .iord(iord_b), .mem_read(mrd_b),
    .mem_write(mwr_b), .ir_write(irw_b), .mem_to_reg(m2r_b), .reg_dst(rdst_b),
    .reg_write(rw_b), .alu_src_a(asa_b), .alu_src_b(asb_b), .alu_op(aop_b),
    .pc_source(psrc_b), .illegal_op(ill_b), .retired(retired_b)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  int ir_count = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step_a(input logic [5:0] op, input logic rdy, input logic [17:0] exp,
                        input string tag);
    @(negedge clk);
    op_a  = op;
    rdy_a = rdy;
    #1;
    check(tag, 32'(cw_a), 32'(exp));
    if (irw_a) ir_count++;
  endtask

  task automatic step_b(input logic [5:0] op, input logic [17:0] exp, input string tag);
    @(negedge clk);
    op_b = op;
    #1;
    check(tag, 32'(cw_b), 32'(exp));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    op_a  = JUNK; op_b  = JUNK;
    rdy_a = 1'b0; rdy_b = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_cw_a", 32'(cw_a), 32'(E_IDLE));
    check("reset_cw_b", 32'(cw_b), 32'(E_IDLE));
    check("reset_ret_a", retired_a, 32'd0);
    check("reset_ret_b", 32'(retired_b), 32'd0);

    // dut_b: mem_ready held low throughout, must be ignored
    @(negedge clk); rst_b = 1'b1;
    step_b(JUNK,     E_FETCH,  "addu_fetch");
    step_b(OP_RTYPE, E_DECODE, "addu_decode");
    step_b(JUNK,     E_EXEC_R, "addu_exec");
    step_b(JUNK,     E_WB_R,   "addu_wb");
    check("addu_ret_before", 32'(retired_b), 32'd0);
    step_b(JUNK,     E_FETCH,  "ori_fetch");
    check("addu_ret_after", 32'(retired_b), 32'd1);
    step_b(OP_ORI,   E_DECODE, "ori_decode");
    step_b(JUNK,     E_EXEC_I, "ori_exec");
    step_b(JUNK,     E_WB_I,   "ori_wb");
    step_b(JUNK,     E_FETCH,  "jal_fetch");
    check("ori_ret", 32'(retired_b), 32'd2);
    step_b(OP_JAL,   E_DECODE, "jal_decode");
    step_b(JUNK,     E_JAL,    "jal_exec");
    step_b(JUNK,     E_FETCH,  "ill_fetch");
    check("jal_ret", 32'(retired_b), 32'd3);
    step_b(JUNK,     E_ILLEGAL, "ill_decode");
    step_b(OP_RTYPE, E_FETCH,   "ill_back_fetch");
    check("ill_ret", 32'(retired_b), 32'd3);
    step_b(OP_SW,    E_DECODE,   "sw_decode");
    step_b(OP_SW,    E_MEM_ADDR, "sw_addr");
    step_b(JUNK,     E_MEM_WR,   "sw_write");
    step_b(JUNK,     E_FETCH,    "lw_fetch");
    check("sw_ret", 32'(retired_b), 32'd4);
    step_b(OP_LW,    E_DECODE,   "lw_decode");
    step_b(OP_LW,    E_MEM_ADDR, "lw_addr");
    step_b(JUNK,     E_MEM_RD,   "lw_read");
    step_b(JUNK,     E_MEM_WB,   "lw_wb");
    step_b(JUNK,     E_FETCH,    "lw_next_fetch");
    check("lw_ret", 32'(retired_b), 32'd5);

    // counter wrap: 17 beq from reset, 4-bit counter
    @(negedge clk); rst_b = 1'b0;
    #1;
    check("wrap_reset_ret", 32'(retired_b), 32'd0);
    @(negedge clk); rst_b = 1'b1;
    for (int i = 0; i < 17; i++) begin
      step_b(JUNK,   E_FETCH,  "beq_fetch");
      check("beq_ret", 32'(retired_b), 32'(i % 16));
      step_b(OP_BEQ, E_DECODE, "beq_decode");
      step_b(JUNK,   E_BRANCH, "beq_branch");
    end
    step_b(JUNK, E_FETCH, "beq_final_fetch");
    check("beq_wrap_end", 32'(retired_b), 32'd1);

    // dut_a: lw with 3 wait cycles in FETCH and 2 in MEM_RD -> 10 cycles
    @(negedge clk); rst_a = 1'b1;
    ir_count = 0;
    step_a(JUNK,  1'b0, E_FETCH_W,  "hs_lw_fetch_w0");
    step_a(JUNK,  1'b0, E_FETCH_W,  "hs_lw_fetch_w1");
    step_a(JUNK,  1'b0, E_FETCH_W,  "hs_lw_fetch_w2");
    step_a(JUNK,  1'b1, E_FETCH,    "hs_lw_fetch_go");
    step_a(OP_LW, 1'b0, E_DECODE,   "hs_lw_decode");
    step_a(OP_LW, 1'b0, E_MEM_ADDR, "hs_lw_addr");
    step_a(JUNK,  1'b0, E_MEM_RD,   "hs_lw_rd_w0");
    step_a(JUNK,  1'b0, E_MEM_RD,   "hs_lw_rd_w1");
    step_a(JUNK,  1'b1, E_MEM_RD,   "hs_lw_rd_go");
    step_a(JUNK,  1'b0, E_MEM_WB,   "hs_lw_wb");
    check("hs_lw_ir_write_once", 32'(ir_count), 32'd1);
    check("hs_lw_ret_before", retired_a, 32'd0);
    step_a(JUNK,  1'b0, E_FETCH_W,  "hs_sw_fetch_w");
    check("hs_lw_ret_after", retired_a, 32'd1);

    // sw held in MEM_WR until mem_ready
    step_a(JUNK,  1'b1, E_FETCH,    "hs_sw_fetch_go");
    step_a(OP_SW, 1'b0, E_DECODE,   "hs_sw_decode");
    step_a(OP_SW, 1'b0, E_MEM_ADDR, "hs_sw_addr");
    step_a(JUNK,  1'b0, E_MEM_WR,   "hs_sw_wr_w0");
    check("hs_sw_ret_hold", retired_a, 32'd1);
    step_a(JUNK,  1'b1, E_MEM_WR,   "hs_sw_wr_go");
    step_a(JUNK,  1'b0, E_FETCH_W,  "hs_sw2_fetch_w");
    check("hs_sw_ret", retired_a, 32'd2);

    // reset asserted mid-MEM_WR: outputs drop immediately, no retire
    step_a(JUNK,  1'b1, E_FETCH,    "hs_sw2_fetch_go");
    step_a(OP_SW, 1'b0, E_DECODE,   "hs_sw2_decode");
    step_a(OP_SW, 1'b0, E_MEM_ADDR, "hs_sw2_addr");
    step_a(JUNK,  1'b0, E_MEM_WR,   "hs_sw2_wr_w0");
    #2 rst_a = 1'b0;
    #1;
    check("hs_abort_cw", 32'(cw_a), 32'(E_IDLE));
    check("hs_abort_ret", retired_a, 32'd0);
    @(negedge clk); rst_a = 1'b1;
    step_a(JUNK,  1'b0, E_FETCH_W,  "hs_after_abort_fetch");
    check("hs_after_abort_ret", retired_a, 32'd0);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
